cache_nway: RTL and testbench
=============================

# cache_nway

Parametrised N-way set-associative, write-through cache with true-LRU replacement and a ready/ack handshake to backing memory. It generalises the fixed two-way cache: configurable associativity, set count and widths, and it fetches on read miss instead of returning stale data. It sits between the CPU load/store path and the memory model, one word per line.

## Interface

- WAYS, 2: associativity; power of two, ≥2
- SETS, 16: number of sets; power of two, ≥2
- DATA_W, 32: word width
- ADDR_W, 32: word address width; must exceed log2(SETS)
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  CPU request; accepted when req_valid && ready
- req_wr  in  1  1 = write, 0 = read
- addr  in  ADDR_W  word address; index = addr[log2(SETS)-1:0], tag = remaining upper bits
- data  in  DATA_W  write data
- ready  out  1  cache idle, can accept a request
- q  out  DATA_W  read data, valid with q_valid
- q_valid  out  1  one-cycle response pulse, for reads and writes
- hit  out  1  qualifies q_valid: request hit in cache
- mem_req  out  1  memory request, held until mem_ack
- mem_wr  out  1  memory write
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  one-cycle completion from memory
- mem_rdata  in  DATA_W  read data, valid with mem_ack

## Operation

- FSM states: IDLE, MEM_RD, MEM_WR, RESP. ready = (state == IDLE).
- IDLE, request accepted: tag compare across all ways of the indexed set in the same cycle; address, data, hit way latched.
- Read hit: go to RESP; q = hit way data, hit = 1; LRU touch.
- Read miss: go to MEM_RD; mem_req = 1, mem_wr = 0, mem_addr = addr. On mem_ack: fill victim way (data, tag, valid = 1), LRU touch, go to RESP with q = mem_rdata, hit = 0.
- Write (hit or miss): cache updated at acceptance (hit way on hit, victim way on miss: write-allocate, no fetch); LRU touch; go to MEM_WR, mem_req = 1, mem_wr = 1, mem_wdata = data. On mem_ack go to RESP, hit reflects lookup result, q = written data.
- RESP: q_valid = 1 for one cycle, then IDLE.
- Victim: lowest-index invalid way; otherwise the way with age WAYS-1.
- LRU: per-way age of log2(WAYS) bits per set, 0 = most recent. Touch of way w with age a: every way with age < a increments, w becomes 0. Ages always a permutation of 0..WAYS-1.
- mem_ack outside MEM_RD/MEM_WR is ignored.

## Timing

- Hit read: accepted at edge T, q_valid high in cycle T+1; ready returns at T+2.
- Miss/write: mem_req rises in cycle T+1, held with stable mem_addr/mem_wr/mem_wdata until mem_ack; q_valid the cycle after the ack edge. Zero-wait memory (ack in first mem_req cycle) gives latency 2.
- Request inputs are sampled only at acceptance; changes while !ready are ignored.
- Reset: all valid bits 0, set ages = way index, state IDLE; ready = 1, q = 0, q_valid = 0, hit = 0, mem_req = 0, mem_wr = 0, mem_addr = 0, mem_wdata = 0. rst wins over every event, including mem_ack in the same cycle; a mid-miss transaction is abandoned and mem_req is low after the reset edge, no fill, no response.

## Structure

- Package cache_pkg: state enum, IDX_W/TAG_W/AGE_W derivation functions.
- Sub-module cache_lru: combinational per-set age update and victim select (inputs: ages, valid bits, touched way; outputs: new ages, victim way); one instance on the indexed set.
- Storage as register arrays indexed [set][way]; no memory macros.

## Test plan

- Reset, then read addr 0 -> mem_req read addr 0; ack with 0x5 -> q = 0x5, hit = 0; repeat read -> q = 0x5, hit = 1, latency 1, no mem_req.
- Write 0x1 to addr 0, write 0x3 to addr 1, read 1, read 0, read 1 -> both writes reach memory; all three reads hit with 0x3, 0x1, 0x3.
- WAYS = 2, SETS = 16: read addrs 0, 16, 0, 32 -> 32 evicts 16 (LRU); read 16 misses, read 0 hits.
- WAYS = 4: fill one set with four tags, touch way 0, insert fifth tag -> way 1 evicted; ages remain a permutation after each step.
- Memory delays ack 5 cycles with addr/data toggling during wait -> mem_addr/mem_wdata stable, ready low, response uses latched request.
- rst asserted in MEM_RD coincident with mem_ack -> no fill, no q_valid, next read of that address misses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and width helpers for the N-way set-associative cache.
package cache_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMemRd,
    StMemWr,
    StResp
  } state_e;

  // Set index width.
  function automatic int unsigned idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  // Tag width: address bits left over after the set index.
  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned sets);
    return addr_w - $clog2(sets);
  endfunction

  // Width of one LRU age field, also the width of a way number.
  function automatic int unsigned age_w(input int unsigned ways);
    return $clog2(ways);
  endfunction

endpackage

// File: rtl/cache_lru.sv
// Combinational true-LRU update and victim selection for one set.
// Ages are packed per way, way w at [w*AGE_W +: AGE_W]; 0 = most recently used.
module cache_lru #(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned AGE_W = 1
) (
  input  logic [WAYS*AGE_W-1:0] ages_i,
  input  logic [WAYS-1:0]       valid_i,
  input  logic [AGE_W-1:0]      touch_i,
  output logic [WAYS*AGE_W-1:0] ages_o,
  output logic [AGE_W-1:0]      victim_o
);

  logic [AGE_W-1:0] touched_age;

  // Touch: ways younger than the touched one age by one, touched way becomes youngest.
  always_comb begin
    touched_age = ages_i[int'(touch_i)*AGE_W +: AGE_W];
    ages_o      = ages_i;
    for (int w = 0; w < WAYS; w++) begin
      if (AGE_W'(w) == touch_i) begin
        ages_o[w*AGE_W +: AGE_W] = '0;
      end else if (ages_i[w*AGE_W +: AGE_W] < touched_age) begin
        ages_o[w*AGE_W +: AGE_W] = ages_i[w*AGE_W +: AGE_W] + AGE_W'(1);
      end
    end
  end

  // Victim: lowest-index invalid way, else the oldest way.
  always_comb begin
    logic found_inv;
    found_inv = 1'b0;
    victim_o  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (ages_i[w*AGE_W +: AGE_W] == AGE_W'(WAYS - 1)) begin
        victim_o = AGE_W'(w);
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!valid_i[w] && !found_inv) begin
        victim_o  = AGE_W'(w);
        found_inv = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-through cache, true LRU, one word per line,
// ready/ack handshake towards backing memory. Read misses fetch and fill;
// writes allocate without fetching and always go through to memory.
module cache_nway
  import cache_pkg::*;
#(
  parameter int unsigned WAYS   = 2,
  parameter int unsigned SETS   = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic              hit,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned IDX_W = idx_w(SETS);
  localparam int unsigned TAG_W = tag_w(ADDR_W, SETS);
  localparam int unsigned AGE_W = age_w(WAYS);

  state_e state_q, state_d;

  logic [DATA_W-1:0]     data_q  [SETS][WAYS];
  logic [DATA_W-1:0]     data_d  [SETS][WAYS];
  logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
  logic [TAG_W-1:0]      tag_d   [SETS][WAYS];
  logic [WAYS-1:0]       valid_q [SETS];
  logic [WAYS-1:0]       valid_d [SETS];
  logic [WAYS*AGE_W-1:0] age_q   [SETS];
  logic [WAYS*AGE_W-1:0] age_d   [SETS];
  logic [WAYS*AGE_W-1:0] age_init;

  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_data_q, req_data_d;
  logic              req_hit_q, req_hit_d;

  logic [DATA_W-1:0] q_q, q_d;
  logic              q_valid_q, q_valid_d;
  logic              hit_q, hit_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [IDX_W-1:0]      lk_idx, req_idx, set_idx;
  logic [TAG_W-1:0]      lk_tag, req_tag;
  logic                  lk_hit;
  logic [AGE_W-1:0]      lk_way, victim_way, touch_way;
  logic [WAYS*AGE_W-1:0] lru_ages;

  assign lk_idx  = addr[IDX_W-1:0];
  assign lk_tag  = addr[ADDR_W-1:IDX_W];
  assign req_idx = req_addr_q[IDX_W-1:0];
  assign req_tag = req_addr_q[ADDR_W-1:IDX_W];

  // Reset ages: each way's age equals its index.
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      age_init[w*AGE_W +: AGE_W] = AGE_W'(w);
    end
  end

  // Tag compare across all ways of the set addressed by the incoming request.
  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
        lk_hit = 1'b1;
        lk_way = AGE_W'(w);
      end
    end
  end

  // The LRU unit looks at the incoming set while idle and at the latched set during a fill.
  always_comb begin
    set_idx   = (state_q == StIdle) ? lk_idx : req_idx;
    touch_way = (state_q == StIdle && lk_hit) ? lk_way : victim_way;
  end

  cache_lru #(
    .WAYS  (WAYS),
    .AGE_W (AGE_W)
  ) u_lru (
    .ages_i   (age_q[set_idx]),
    .valid_i  (valid_q[set_idx]),
    .touch_i  (touch_way),
    .ages_o   (lru_ages),
    .victim_o (victim_way)
  );

  // Next-state, storage updates and registered outputs.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    tag_d       = tag_q;
    valid_d     = valid_q;
    age_d       = age_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_hit_d   = req_hit_q;
    q_d         = q_q;
    q_valid_d   = 1'b0;
    hit_d       = hit_q;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          req_addr_d = addr;
          req_data_d = data;
          req_hit_d  = lk_hit;
          if (req_wr) begin
            // Write-allocate: hit way on hit, victim on miss, no fetch.
            data_d[lk_idx][touch_way]  = data;
            tag_d[lk_idx][touch_way]   = lk_tag;
            valid_d[lk_idx][touch_way] = 1'b1;
            age_d[lk_idx]              = lru_ages;
            mem_req_d                  = 1'b1;
            mem_wr_d                   = 1'b1;
            mem_addr_d                 = addr;
            mem_wdata_d                = data;
            state_d                    = StMemWr;
          end else if (lk_hit) begin
            age_d[lk_idx] = lru_ages;
            q_d           = data_q[lk_idx][lk_way];
            hit_d         = 1'b1;
            q_valid_d     = 1'b1;
            state_d       = StResp;
          end else begin
            mem_req_d  = 1'b1;
            mem_wr_d   = 1'b0;
            mem_addr_d = addr;
            state_d    = StMemRd;
          end
        end
      end
      StMemRd: begin
        if (mem_ack) begin
          data_d[req_idx][victim_way]  = mem_rdata;
          tag_d[req_idx][victim_way]   = req_tag;
          valid_d[req_idx][victim_way] = 1'b1;
          age_d[req_idx]               = lru_ages;
          mem_req_d                    = 1'b0;
          q_d                          = mem_rdata;
          hit_d                        = 1'b0;
          q_valid_d                    = 1'b1;
          state_d                      = StResp;
        end
      end
      StMemWr: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_wr_d  = 1'b0;
          q_d       = req_data_q;
          hit_d     = req_hit_q;
          q_valid_d = 1'b1;
          state_d   = StResp;
        end
      end
      StResp: begin
        hit_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and storage registers; reset overrides everything, including a same-cycle mem_ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      valid_q     <= '{default: '0};
      for (int s = 0; s < SETS; s++) begin
        age_q[s] <= age_init;
      end
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_hit_q   <= 1'b0;
      q_q         <= '0;
      q_valid_q   <= 1'b0;
      hit_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      tag_q       <= tag_d;
      valid_q     <= valid_d;
      age_q       <= age_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      req_hit_q   <= req_hit_d;
      q_q         <= q_d;
      q_valid_q   <= q_valid_d;
      hit_q       <= hit_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign ready     = (state_q == StIdle);
  assign q         = q_q;
  assign q_valid   = q_valid_q;
  assign hit       = hit_q;
  assign mem_req   = mem_req_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_cache_nway.sv
// Directed bench for cache_nway: a 2-way and a 4-way instance share one stimulus
// bus; sel steers requests and memory acks to one of them and picks its outputs.
module tb_cache_nway;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid, req_wr, mem_ack;
  logic [31:0] addr, data, mem_rdata;

  logic        ready_a, q_valid_a, hit_a, mem_req_a, mem_wr_a;
  logic [31:0] q_a, mem_addr_a, mem_wdata_a;
  logic        ready_b, q_valid_b, hit_b, mem_req_b, mem_wr_b;
  logic [31:0] q_b, mem_addr_b, mem_wdata_b;

  logic        ready, q_valid, hit, mem_req, mem_wr;
  logic [31:0] q, mem_addr, mem_wdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign ready     = sel ? ready_b     : ready_a;
  assign q_valid   = sel ? q_valid_b   : q_valid_a;
  assign hit       = sel ? hit_b       : hit_a;
  assign mem_req   = sel ? mem_req_b   : mem_req_a;
  assign mem_wr    = sel ? mem_wr_b    : mem_wr_a;
  assign q         = sel ? q_b         : q_a;
  assign mem_addr  = sel ? mem_addr_b  : mem_addr_a;
  assign mem_wdata = sel ? mem_wdata_b : mem_wdata_a;

  cache_nway #(.WAYS(2), .SETS(16), .DATA_W(32), .ADDR_W(32)) u_a (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid & ~sel),
    .req_wr    (req_wr),
    .addr      (addr),
    .data      (data),
    .ready     (ready_a),
    .q         (q_a),
    .q_valid   (q_valid_a),
    .hit       (hit_a),
    .mem_req   (mem_req_a),
    .mem_wr    (mem_wr_a),
    .mem_addr  (mem_addr_a),
    .mem_wdata (mem_wdata_a),
    .mem_ack   (mem_ack & ~sel),
    .mem_rdata (mem_rdata)
  );

  cache_nway #(.WAYS(4), .SETS(16), .DATA_W(32), .ADDR_W(32)) u_b (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid & sel),
    .req_wr    (req_wr),
    .addr      (addr),
    .data      (data),
    .ready     (ready_b),
    .q         (q_b),
    .q_valid   (q_valid_b),
    .hit       (hit_b),
    .mem_req   (mem_req_b),
    .mem_wr    (mem_wr_b),
    .mem_addr  (mem_addr_b),
    .mem_wdata (mem_wdata_b),
    .mem_ack   (mem_ack & sel),
    .mem_rdata (mem_rdata)
  );

  task automatic check(input string tg, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tg, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for ready, then present one request for exactly one edge.
  task automatic issue(input string tg, input bit wr, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    while (!ready && n < 20) begin
      tick();
      n++;
    end
    check({tg, ":ready"}, {31'b0, ready}, 32'd1);
    req_valid = 1'b1;
    req_wr    = wr;
    addr      = a;
    data      = d;
    tick();
    req_valid = 1'b0;
  endtask

  // One transaction. Read hit: d is the expected q. Otherwise memory acks
  // after dly wait cycles, during which the request bus is scrambled.
  task automatic xact(input string tg, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input bit exp_hit, input int dly, input logic [31:0] rdata);
    logic [31:0] exp_q;
    issue(tg, wr, a, d);
    if (!wr && exp_hit) begin
      check({tg, ":qv"}, {31'b0, q_valid}, 32'd1);
      check({tg, ":hit"}, {31'b0, hit}, 32'd1);
      check({tg, ":q"}, q, d);
      check({tg, ":nomem"}, {31'b0, mem_req}, 32'd0);
      if (mem_req) begin
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
      end
      tick();
    end else begin
      exp_q = wr ? d : rdata;
      check({tg, ":mreq"}, {31'b0, mem_req}, 32'd1);
      check({tg, ":mwr"}, {31'b0, mem_wr}, {31'b0, wr});
      check({tg, ":maddr"}, mem_addr, a);
      if (wr) check({tg, ":mwdata"}, mem_wdata, d);
      for (int i = 0; i < dly; i++) begin
        req_valid = 1'($urandom_range(0, 1));
        req_wr    = ~wr;
        addr      = $urandom;
        data      = $urandom;
        tick();
        check({tg, ":hold_req"}, {31'b0, mem_req}, 32'd1);
        check({tg, ":hold_addr"}, mem_addr, a);
        check({tg, ":busy"}, {31'b0, ready}, 32'd0);
        check({tg, ":noqv"}, {31'b0, q_valid}, 32'd0);
        if (wr) check({tg, ":hold_wdata"}, mem_wdata, d);
      end
      req_valid = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = rdata;
      tick();
      mem_ack = 1'b0;
      check({tg, ":qv"}, {31'b0, q_valid}, 32'd1);
      check({tg, ":hit"}, {31'b0, hit}, {31'b0, exp_hit});
      check({tg, ":q"}, q, exp_q);
      check({tg, ":mreq_drop"}, {31'b0, mem_req}, 32'd0);
      tick();
    end
  endtask

  initial begin
    sel       = 1'b0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    addr      = '0;
    data      = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    tick();
    tick();

    // Reset state
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_q", q, 32'd0);
    check("rst_qv", {31'b0, q_valid}, 32'd0);
    check("rst_hit", {31'b0, hit}, 32'd0);
    check("rst_mreq", {31'b0, mem_req}, 32'd0);
    check("rst_mwr", {31'b0, mem_wr}, 32'd0);
    check("rst_maddr", mem_addr, 32'd0);
    check("rst_mwdata", mem_wdata, 32'd0);
    check("rst_age_b", {24'b0, u_b.age_q[2]}, 32'hE4);
    rst = 1'b0;
    tick();

    // Miss then hit on address 0
    xact("rd0_miss", 1'b0, 32'd0, 32'd0, 1'b0, 0, 32'h5);
    xact("rd0_hit", 1'b0, 32'd0, 32'h5, 1'b1, 0, 32'h0);

    // Write-through, hit and allocate, then read back
    xact("wr0", 1'b1, 32'd0, 32'h1, 1'b1, 0, 32'h0);
    xact("wr1", 1'b1, 32'd1, 32'h3, 1'b0, 0, 32'h0);
    xact("rd1_a", 1'b0, 32'd1, 32'h3, 1'b1, 0, 32'h0);
    xact("rd0_a", 1'b0, 32'd0, 32'h1, 1'b1, 0, 32'h0);
    xact("rd1_b", 1'b0, 32'd1, 32'h3, 1'b1, 0, 32'h0);

    // 2-way LRU in set 0: 16 fills way 1, 0 touched, 32 evicts 16
    xact("rd16_miss", 1'b0, 32'd16, 32'd0, 1'b0, 0, 32'h16);
    xact("rd0_touch", 1'b0, 32'd0, 32'h1, 1'b1, 0, 32'h0);
    xact("rd32_miss", 1'b0, 32'd32, 32'd0, 1'b0, 0, 32'h32);
    xact("rd0_kept", 1'b0, 32'd0, 32'h1, 1'b1, 0, 32'h0);
    xact("rd16_gone", 1'b0, 32'd16, 32'd0, 1'b0, 0, 32'h61);

    // Slow memory with the request bus scrambled while waiting
    xact("wr5_slow", 1'b1, 32'd5, 32'hAB, 1'b0, 5, 32'h0);
    xact("rd7_slow", 1'b0, 32'd7, 32'd0, 1'b0, 5, 32'h77);
    xact("rd5_hit", 1'b0, 32'd5, 32'hAB, 1'b1, 0, 32'h0);

    // Reset coincident with mem_ack during a read miss
    issue("rd9_abort", 1'b0, 32'd9, 32'd0);
    check("rd9_abort:mreq", {31'b0, mem_req}, 32'd1);
    rst       = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h99;
    tick();
    rst     = 1'b0;
    mem_ack = 1'b0;
    check("abort:qv", {31'b0, q_valid}, 32'd0);
    check("abort:mreq", {31'b0, mem_req}, 32'd0);
    check("abort:ready", {31'b0, ready}, 32'd1);
    tick();
    check("abort:qv_late", {31'b0, q_valid}, 32'd0);
    xact("rd9_remiss", 1'b0, 32'd9, 32'd0, 1'b0, 0, 32'h9A);

    // 4-way LRU in set 2
    sel = 1'b1;
    tick();
    xact("b_rd2", 1'b0, 32'd2, 32'd0, 1'b0, 0, 32'h100);
    check("b_age1", {24'b0, u_b.age_q[2]}, 32'hE4);
    xact("b_rd18", 1'b0, 32'd18, 32'd0, 1'b0, 0, 32'h101);
    check("b_age2", {24'b0, u_b.age_q[2]}, 32'hE1);
    xact("b_rd34", 1'b0, 32'd34, 32'd0, 1'b0, 0, 32'h102);
    check("b_age3", {24'b0, u_b.age_q[2]}, 32'hC6);
    xact("b_rd50", 1'b0, 32'd50, 32'd0, 1'b0, 2, 32'h103);
    check("b_age4", {24'b0, u_b.age_q[2]}, 32'h1B);
    xact("b_touch2", 1'b0, 32'd2, 32'h100, 1'b1, 0, 32'h0);
    check("b_age5", {24'b0, u_b.age_q[2]}, 32'h6C);
    xact("b_rd66", 1'b0, 32'd66, 32'd0, 1'b0, 0, 32'h104);
    check("b_age6", {24'b0, u_b.age_q[2]}, 32'hB1);
    xact("b_hit2", 1'b0, 32'd2, 32'h100, 1'b1, 0, 32'h0);
    xact("b_hit34", 1'b0, 32'd34, 32'h102, 1'b1, 0, 32'h0);
    xact("b_hit50", 1'b0, 32'd50, 32'h103, 1'b1, 0, 32'h0);
    xact("b_hit66", 1'b0, 32'd66, 32'h104, 1'b1, 0, 32'h0);
    xact("b_rd18_gone", 1'b0, 32'd18, 32'd0, 1'b0, 0, 32'h181);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
